multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multi-cycle FSM successor to the single-cycle opcode decoder; drives the multi-cycle datapath (shared memory, IR, A/B/ALUOut registers).
- Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction and adds load, store and jump support.
- Memory accesses use a ready handshake with a watchdog, and the block flags illegal opcodes.
- Opcode and ALU-op widths are parametrised.

Parameters:
- OP_W, 6, opcode width of instruccion.
- ALUOP_W, 6, width of ALUOP; opcode is zero-extended or truncated to this width.
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready; 0 disables the watchdog.

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- instruccion  in  OP_W  opcode field from IR; sampled in DECODE only.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  PC load if ALU zero.
- jump  out  1  PC source = jump target.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  1 = write-back data from MDR.
- RegDst  out  1  1 = rt destination (I-type), 0 = rd (R-type).
- RegWrite  out  1  register-file write.
- ALUSrcA  out  1  0 = PC, 1 = reg A.
- ALUSrcB  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = shifted imm.
- ALUOP  out  ALUOP_W  ALU operation code.
- instr_done  out  1  one-cycle pulse in an instruction's last state.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- mem_fault  out  1  one-cycle pulse on a watchdog expiry.

Behaviour:
- Reset: state = FETCH, wait_cnt = 0, op_q = 0. While reset is high, every output is 0. First FETCH outputs appear the cycle after reset deasserts.
- Outputs are Moore (state and op_q), except IRWrite/PCWrite in FETCH, which are gated by mem_ready.
- Opcodes (package constants):
  - RTYPE 000000.
  - ALU-immediate 000001, 000111, 000100, 001010.
  - BRANCH 000011, 000110, 001001.
  - LOAD 100011, STORE 101011, JUMP 000010.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOP=ALU_ADD(000001).
  - mem_ready=1: IRWrite=1 and PCWrite=1 that cycle; next state DECODE.
  - mem_ready=0: stay in FETCH.
- DECODE: latch op_q <= instruccion; ALUSrcA=0, ALUSrcB=3, ALUOP=ALU_ADD (branch target into ALUOut). Next state:
  - RTYPE -> EXEC_R.
  - ALU-immediate -> EXEC_I.
  - BRANCH -> BRANCH.
  - JUMP -> JUMP.
  - LOAD/STORE -> MEM_ADDR.
  - Any other opcode -> FETCH with illegal_op=1.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOP=op_q; next WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOP=op_q; next WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=0, RegDst = (op_q != RTYPE); instr_done=1; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOP=op_q, Branch=1; instr_done=1; next FETCH.
- JUMP: jump=1, PCWrite=1; instr_done=1; next FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOP=ALU_ADD. Next MEM_RD if op_q=LOAD, else MEM_WR.
- MEM_RD: MemRead=1, IorD=1; MDR loads on mem_ready; next MEM_WB on mem_ready.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=1; instr_done=1; next FETCH.
- MEM_WR: MemWrite=1, IorD=1. On mem_ready: instr_done=1, next FETCH.
- Latency with zero-wait memory, including FETCH: R/I = 4, BRANCH = 3, JUMP = 3, LOAD = 5, STORE = 4 cycles. Each wait cycle adds 1.
- Watchdog (FETCH, MEM_RD, MEM_WR):
  - wait_cnt clears on entry to the state.
  - Increments each cycle mem_ready=0.
  - If wait_cnt == MEM_TIMEOUT-1 and mem_ready=0: mem_fault=1, next FETCH with wait_cnt=0, no register write, no PC update.
  - mem_ready=1 on the expiry cycle wins: normal completion, no fault.
  - Counter width is clog2(MEM_TIMEOUT+1). With MEM_TIMEOUT=0 it waits indefinitely.
- Reset mid-instruction aborts it with no pulses and no writes.
- Unreachable state encodings -> FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - opcode constants and ALU_ADD;
  - ALUSrcB selector constants;
  - function is_alu_imm(op).
- Single sub-module mem_watchdog: counter and expiry compare, with start/ready/expired ports.
- FSM and output decode stay in the top module.

Test Plan:
- Opcode 000000, mem_ready tied 1 -> states FETCH,DECODE,EXEC_R,WB_ALU; RegWrite=1 with RegDst=0 on cycle 4; instr_done on cycle 4; ALUOP=000000 in EXEC_R.
- Opcode 100011, mem_ready low for 3 cycles in MEM_RD -> 8 cycles total; MemtoReg=1, RegWrite=1, RegDst=1 in MEM_WB; no mem_fault.
- Opcode 101011 -> MemWrite=1, IorD=1 held until mem_ready; RegWrite never asserted; instr_done in the MEM_WR cycle where mem_ready=1.
- Opcode 000010 -> jump=1 and PCWrite=1 in cycle 3; then FETCH. Opcode 000110 -> Branch=1, ALUOP=000110 in cycle 3.
- Opcode 111111 -> illegal_op pulse in DECODE; FETCH next cycle; no RegWrite/MemWrite.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> mem_fault on 4th wait cycle, FETCH re-entered with counter cleared. Then reset asserted during MEM_RD -> all outputs 0; FETCH the cycle after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared state encoding, opcode map and datapath selector constants for the
// multi-cycle control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_ALU   = 4'd4,
    BRANCH   = 4'd5,
    JUMP     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    MEM_WB   = 4'd9,
    MEM_WR   = 4'd10
  } state_t;

  // Opcodes are held zero-extended to 32 bits so the compares work for any OP_W.
  localparam logic [31:0] OPC_RTYPE  = 32'h00;
  localparam logic [31:0] OPC_IMM_01 = 32'h01;
  localparam logic [31:0] OPC_IMM_07 = 32'h07;
  localparam logic [31:0] OPC_IMM_04 = 32'h04;
  localparam logic [31:0] OPC_IMM_0A = 32'h0A;
  localparam logic [31:0] OPC_BR_03  = 32'h03;
  localparam logic [31:0] OPC_BR_06  = 32'h06;
  localparam logic [31:0] OPC_BR_09  = 32'h09;
  localparam logic [31:0] OPC_LOAD   = 32'h23;
  localparam logic [31:0] OPC_STORE  = 32'h2B;
  localparam logic [31:0] OPC_JUMP   = 32'h02;

  localparam int unsigned ALU_ADD = 1;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  function automatic logic is_alu_imm(input logic [31:0] op);
    return (op == OPC_IMM_01) || (op == OPC_IMM_07) ||
           (op == OPC_IMM_04) || (op == OPC_IMM_0A);
  endfunction

  function automatic logic is_branch(input logic [31:0] op);
    return (op == OPC_BR_03) || (op == OPC_BR_06) || (op == OPC_BR_09);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting on mem_ready and flags expiry after TIMEOUT
// wait cycles; TIMEOUT = 0 never expires.
module mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;

  assign expired = (TIMEOUT > 0) && active && !ready && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || start || expired) begin
      cnt <= '0;
    end else if (active && !ready) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle datapath sequencer: fetch/decode/execute/memory/write-back with
// handshaked memory, a wait watchdog and illegal-opcode reporting.
//
// state    | meaning
// ---------+--------------------------------------------------
// FETCH    | read instruction at PC, load IR and PC+4 on ready
// DECODE   | latch opcode, precompute branch target
// EXEC_R   | ALU on A op B
// EXEC_I   | ALU on A op sign-extended immediate
// WB_ALU   | write ALUOut to register file
// BRANCH   | compare A/B, load PC from ALUOut if zero
// JUMP     | load PC with jump target
// MEM_ADDR | compute A + immediate effective address
// MEM_RD   | read memory at ALUOut into MDR
// MEM_WB   | write MDR to register file
// MEM_WR   | write B to memory at ALUOut
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int ALUOP_W     = 6,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    instruccion,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               Branch,
  output logic               jump,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_fault
);

  state_t          state, state_next;
  logic [OP_W-1:0] op_q;
  logic [31:0]     op_in, op_reg;
  logic            wd_start, wd_active, wd_expired;

  assign op_in     = 32'(instruccion);
  assign op_reg    = 32'(op_q);
  assign wd_active = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign wd_start  = (state_next != state);

  mem_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (wd_start),
    .active  (wd_active),
    .ready   (mem_ready),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      op_q  <= '0;
    end else begin
      state <= state_next;
      if (state == DECODE) op_q <= instruccion;
    end
  end

  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    jump       = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUOP      = '0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    mem_fault  = 1'b0;

    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOP   = ALUOP_W'(ALU_ADD);
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = DECODE;
        end else if (wd_expired) begin
          mem_fault  = 1'b1;
          state_next = FETCH;
        end
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        ALUOP   = ALUOP_W'(ALU_ADD);
        if (op_in == OPC_RTYPE)                           state_next = EXEC_R;
        else if (is_alu_imm(op_in))                       state_next = EXEC_I;
        else if (is_branch(op_in))                        state_next = BRANCH;
        else if (op_in == OPC_JUMP)                       state_next = JUMP;
        else if (op_in == OPC_LOAD || op_in == OPC_STORE) state_next = MEM_ADDR;
        else begin
          illegal_op = 1'b1;
          state_next = FETCH;
        end
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUOP      = ALUOP_W'(op_q);
        state_next = WB_ALU;
      end
      EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOP      = ALUOP_W'(op_q);
        state_next = WB_ALU;
      end
      WB_ALU: begin
        RegWrite   = 1'b1;
        RegDst     = (op_reg != OPC_RTYPE);
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUOP      = ALUOP_W'(op_q);
        Branch     = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        jump       = 1'b1;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOP      = ALUOP_W'(ALU_ADD);
        state_next = (op_reg == OPC_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_next = MEM_WB;
        end else if (wd_expired) begin
          mem_fault  = 1'b1;
          state_next = FETCH;
        end
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = FETCH;
        end else if (wd_expired) begin
          mem_fault  = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase

    // Reset silences every control line, including the one-cycle pulses.
    if (reset) begin
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      jump       = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      MemtoReg   = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      ALUOP      = '0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      mem_fault  = 1'b0;
    end
  end

endmodule
